seq_chunk_adder: RTL
====================

// Module: seq_chunk_adder
// PURPOSE
//  Parametrised multi-cycle add/subtract unit. Successor to the fixed 4-bit ripple adder.
//  Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB chunk first,
//  with a registered carry between chunks (a time-multiplexed cascade of 4-bit adders).
//  Operands enter and results leave through valid/ready handshakes.
//  Results carry flags: cout/borrow, signed overflow and zero.
// PARAMETERS
//  WIDTH  16  operand/result width; must be a multiple of CHUNK, >= CHUNK
//  CHUNK   4  bits added per cycle; NCH = WIDTH/CHUNK chunk cycles per operation
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      synchronous active-low reset
//  in_valid   in   1      operand set valid
//  in_ready   out  1      unit can accept operands
//  inA        in   WIDTH  operand A
//  inB        in   WIDTH  operand B
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: A+B+cin   1: A-B-cin
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      add: carry out of MSB; sub: borrow (1 = A < B+cin unsigned)
//  ovf        out  1      signed two's-complement overflow
//  zero       out  1      out == 0
// BEHAVIOUR
//  - Reset (rst_n=0 at a rising edge): state=IDLE, chunk counter=0, carry reg=0.
//    in_ready=1 after the reset edge. out_valid=0. out, cout, ovf, zero = 0.
//    A reset at any point, including mid-CALC or in DONE, aborts the operation with no partial output.
//  - FSM states: IDLE -> CALC -> DONE -> IDLE.
//  - IDLE:
//    - in_ready=1.
//    - On in_valid&&in_ready, capture inA into the A register. Capture B as inB (sub=0) or ~inB (sub=1).
//    - Set carry = cin (sub=0) or ~cin (sub=1). Latch the sub flag. Set counter=0. Go to CALC.
//    - The input ports are ignored after capture.
//  - CALC:
//    - in_ready=0.
//    - Each cycle: {c,s} = A[k] + B[k] + carry, where k is the counter and X[k] = X[k*CHUNK +: CHUNK].
//      Write s into out[k] and c into carry; increment the counter.
//    - On the chunk k = NCH-1, also register c_msb_in = the carry into bit WIDTH-1.
//    - After chunk NCH-1 go to DONE.
//    - out_valid rises exactly NCH clock edges after the accepting edge.
//  - DONE:
//    - out_valid=1, in_ready=0.
//    - cout = carry (sub=0) or ~carry (sub=1).
//    - ovf = carry ^ c_msb_in.
//    - zero = (out == 0).
//    - All outputs stay stable while out_valid && !out_ready.
//    - On out_ready=1, go to IDLE; out_valid=0 the next cycle.
//  - Result outputs hold their last value in IDLE and are overwritten chunk-by-chunk during CALC.
//    Consumers sample them only when out_valid=1.
//  - Throughput: one operation per NCH+2 cycles when out_ready is held high.
//  - Changes on in_valid, inA, inB, cin or sub outside IDLE have no effect.
//  - CHUNK == WIDTH is legal: NCH=1, latency 1 cycle.
//  - No combinational path from any input to any output. All outputs are registered.
// TESTING  (WIDTH=16, CHUNK=4 unless noted)
//  1. A=0x1234, B=0x4321, cin=0, sub=0 -> out=0x5555, cout=0, ovf=0, zero=0.
//     out_valid exactly 4 edges after accept.
//  2. A=0xFFFF, B=0x0001, cin=0, sub=0 -> out=0x0000, cout=1, ovf=0, zero=1.
//     Covers carry rippling through all chunks.
//  3. A=0x7FFF, B=0x0001, add -> out=0x8000, ovf=1, cout=0.
//     A=0x0005, B=0x0007, cin=0, sub=1 -> out=0xFFFE, cout=1, ovf=0.
//  4. Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid/inA.
//     -> outputs unchanged, in_ready=0, no second capture.
//     Then out_ready=1 -> in_ready=1 the next cycle.
//  5. Assert rst_n=0 for 1 cycle at chunk 2 of an operation.
//     -> out_valid=0 and all outputs 0 after the edge, in_ready=1.
//     The next op A=0x0100, B=0x0100 -> 0x0200.
//  6. Random regression of 10k ops vs. the reference model {cout,out} = A +/- B +/- cin.
//     Run with random out_ready, for (WIDTH,CHUNK) = (16,4), (8,8), (32,4), (12,3).

Source files
------------

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder
//   Multi-cycle add/subtract unit. A WIDTH-bit operation is processed CHUNK
//   bits per clock, LSB chunk first. A registered carry links one chunk to
//   the next.
//
// Ports
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   in_valid/in_ready    operand handshake (inA, inB, cin, sub)
//   out_valid/out_ready  result handshake (out, cout, ovf, zero)
//   cout                 carry out on add; borrow (A < B+cin) on sub
//   ovf                  signed two's-complement overflow
//   zero                 out == 0
//
// All outputs are decoded from, or are, flops. No input reaches an output
// combinationally.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0]   sum;
  logic             last_chunk;
  logic             c_msb_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    // Select the active chunk of each operand.
    a_ch = '0;
    b_ch = '0;
    for (int k = 0; k < NCH; k++) begin
      if (cnt_q == CW'(k)) begin
        a_ch = a_q[k*CHUNK +: CHUNK];
        b_ch = b_q[k*CHUNK +: CHUNK];
      end
    end
    sum        = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
    last_chunk = (cnt_q == CW'(NCH - 1));
    // Carry into a bit is a ^ b ^ s at that bit. At the top chunk this gives
    // the carry into bit WIDTH-1, which the overflow check needs.
    c_msb_in   = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ sum[CHUNK-1];

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + ~borrow_in.
          a_d     = inA;
          b_d     = sub ? ~inB : inB;
          carry_d = cin ^ sub;
          sub_d   = sub;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        for (int k = 0; k < NCH; k++) begin
          if (cnt_q == CW'(k)) out_d[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
        end
        carry_d = sum[CHUNK];
        if (last_chunk) begin
          // Flags are registered on the final chunk edge. They are therefore
          // stable for the whole time the unit is in DONE.
          cout_d  = sum[CHUNK] ^ sub_q;
          ovf_d   = sum[CHUNK] ^ c_msb_in;
          zero_d  = (out_d == '0);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
endmodule
